// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the execute-feed stage: opcodes, instruction layout and field widths.
package cpu_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_AND  = 1;
  localparam int OP_OR   = 2;
  localparam int OP_SLL  = 3;
  localparam int OP_SLR  = 4;
  localparam int OP_SLRA = 5;
  localparam int OP_ROL  = 6;
  localparam int OP_ROR  = 7;
  localparam int OP_NOT  = 8;
  localparam int OP_NEG  = 9;
  localparam int OP_MUL  = 10;
  localparam int OP_DIV  = 11;

  localparam int OPCODE_COUNT = OP_DIV + 1;

  localparam int FIELD_W = 5;
  localparam int IMM_W   = 11;
  localparam int INSTR_W = 32;

  // [31:27]op [26:22]rd [21:17]rs1 [16:12]rs2 [11]imm_sel [10:0]imm11
  typedef struct packed {
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rs1;
    logic [FIELD_W-1:0] rs2;
    logic               imm_sel;
    logic [IMM_W-1:0]   imm11;
  } instr_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one clocked write port.
// r0 is hardwired to zero; a same-cycle write is forwarded to the read ports.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wdata
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_hit;

  assign wr_hit = we && (wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[wa] <= wdata;
    end
  end

  assign rdata1 = (ra1 == '0) ? '0 : (wr_hit && (wa == ra1)) ? wdata : mem[ra1];
  assign rdata2 = (ra2 == '0) ? '0 : (wr_hit && (wa == ra2)) ? wdata : mem[ra2];

endmodule

// File: rtl/alu_operand_issue.sv
// Execute-feed stage: decodes an instruction, reads operands, tracks outstanding
// destinations in a scoreboard and presents registered A/B/op to the ALU.
module alu_operand_issue
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int OP_W    = 5,
  parameter int NUM_OPS = OPCODE_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_op,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  localparam int NREG = 2 ** REG_AW;

  instr_t              instr;
  logic [OP_W-1:0]     dec_op;
  logic [REG_AW-1:0]   dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0]   rdata1, rdata2, imm_ext;
  logic [NREG-1:0]     pend, pend_eff, wb_mask, set_mask;
  logic                wb_hit, hazard, in_fire, legal, issue;

  assign instr   = instr_t'(in_instr);
  assign dec_op  = OP_W'(instr.op);
  assign dec_rd  = REG_AW'(instr.rd);
  assign dec_rs1 = REG_AW'(instr.rs1);
  assign dec_rs2 = REG_AW'(instr.rs2);
  assign imm_ext = {{(DATA_W-IMM_W){instr.imm11[IMM_W-1]}}, instr.imm11};

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra1    (dec_rs1),
    .ra2    (dec_rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_en),
    .wa     (wb_rd),
    .wdata  (wb_data)
  );

  // A writeback landing this cycle retires its pend bit before the hazard check.
  assign wb_hit   = wb_en && (wb_rd != '0);
  assign wb_mask  = wb_hit ? (NREG'(1) << wb_rd) : '0;
  assign pend_eff = pend & ~wb_mask;

  assign hazard   = pend_eff[dec_rs1] | (!instr.imm_sel & pend_eff[dec_rs2]) | pend_eff[dec_rd];
  assign in_ready = (!out_valid | out_ready) & !hazard;
  assign in_fire  = in_valid & in_ready;
  assign legal    = dec_op < OP_W'(NUM_OPS);
  assign issue    = in_fire & legal;
  assign set_mask = (issue && dec_rd != '0) ? (NREG'(1) << dec_rd) : '0;

  // Set is OR'd after the clear so a same-register issue wins over writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_eff | set_mask;
  end

  // Decode -> ALU operand register boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_rd    <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= in_fire & ~legal;
      if (issue) begin
        out_valid <= 1'b1;
        out_a     <= rdata1;
        out_b     <= instr.imm_sel ? imm_ext : rdata2;
        out_op    <= dec_op;
        out_rd    <= dec_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios plus a randomized stream checked
// against an array-based architectural model of registers, pending bits and the output slot.
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_op, out_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int total = 0;
  int passed = 0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];
  logic        m_ov, m_ill;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_op, m_rd;

  alu_operand_issue #(
    .DATA_W (32), .REG_AW (5), .OP_W (5), .NUM_OPS (12)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_a (out_a), .out_b (out_b), .out_op (out_op), .out_rd (out_rd),
    .wb_en (wb_en), .wb_rd (wb_rd), .wb_data (wb_data),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic isel, input logic [10:0] imm);
    return {op, rd, rs1, rs2, isel, imm};
  endfunction

  function automatic bit m_busy(input logic [4:0] x);
    return (x != 0) && m_pend[x] && !(wb_en && wb_rd == x);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] x);
    if (x == 0) return 32'd0;
    if (wb_en && wb_rd == x) return wb_data;
    return m_reg[x];
  endfunction

  function automatic bit m_ready();
    logic [4:0] rd, rs1, rs2;
    bit isel;
    rd = in_instr[26:22]; rs1 = in_instr[21:17]; rs2 = in_instr[16:12]; isel = in_instr[11];
    return (!m_ov || out_ready) && !(m_busy(rs1) || (!isel && m_busy(rs2)) || m_busy(rd));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
    m_ov = 0; m_ill = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
  endtask

  task automatic idle();
    in_valid = 0; in_instr = 0; out_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Advance one clock, updating the model from the inputs that were stable before the edge.
  task automatic cycle();
    logic [4:0] op, rd, rs1, rs2;
    bit isel, fire, wbx, ordy;
    logic [10:0] imm;
    logic [31:0] va, vb, wd;
    logic [4:0] wr;
    {op, rd, rs1, rs2, isel, imm} = in_instr;
    fire = in_valid && m_ready();
    va = m_read(rs1);
    vb = isel ? {{21{imm[10]}}, imm} : m_read(rs2);
    wbx = wb_en && wb_rd != 0; wr = wb_rd; wd = wb_data; ordy = out_ready;
    @(posedge clk);
    if (wbx) begin m_reg[wr] = wd; m_pend[wr] = 0; end
    if (fire && op < 12) begin
      if (rd != 0) m_pend[rd] = 1;
      m_ov = 1; m_a = va; m_b = vb; m_op = op; m_rd = rd;
    end else if (ordy) begin
      m_ov = 0;
    end
    m_ill = fire && op >= 12;
    #1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_a !== 32'd0) $display("FAIL reset_out_a got %h want 0", out_a); else passed++;
    total++; if (out_b !== 32'd0) $display("FAIL reset_out_b got %h want 0", out_b); else passed++;
    total++; if (out_op !== 5'd0 || out_rd !== 5'd0) $display("FAIL reset_op_rd got %0d/%0d want 0/0", out_op, out_rd); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", illegal); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    rst_n = 1;
    cycle();
  endtask

  task automatic test_basic();
    idle();
    wb_en = 1; wb_rd = 1; wb_data = 5; cycle();
    wb_rd = 2; wb_data = 7; cycle();
    wb_en = 0;
    in_valid = 1; in_instr = mk(5'd0, 5'd3, 5'd1, 5'd2, 1'b0, 11'd0);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready got %b want 1", in_ready); else passed++;
    cycle();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else passed++;
    total++; if (out_a !== 32'd5 || out_b !== 32'd7) $display("FAIL basic_ab got %0d/%0d want 5/7", out_a, out_b); else passed++;
    total++; if (out_op !== 5'd0 || out_rd !== 5'd3) $display("FAIL basic_op_rd got %0d/%0d want 0/3", out_op, out_rd); else passed++;
  endtask

  task automatic test_raw_bypass();
    in_valid = 1; in_instr = mk(5'd0, 5'd4, 5'd3, 5'd1, 1'b0, 11'd0);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL raw_stall got %b want 0", in_ready); else passed++;
    cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL raw_drain got %b want 0", out_valid); else passed++;
    wb_en = 1; wb_rd = 3; wb_data = 12;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL raw_bypass_ready got %b want 1", in_ready); else passed++;
    cycle();
    in_valid = 0; wb_en = 0;
    total++; if (out_a !== 32'd12 || out_b !== 32'd5 || out_rd !== 5'd4) $display("FAIL raw_bypass_ops got a=%0d b=%0d rd=%0d want 12/5/4", out_a, out_b, out_rd); else passed++;
    wb_en = 1; wb_rd = 4; wb_data = 17; cycle();
    wb_en = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_instr = mk(5'd1, 5'd9, 5'd1, 5'd2, 1'b0, 11'd0);
    cycle();
    in_instr = mk(5'd2, 5'd10, 5'd2, 5'd1, 1'b0, 11'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); else passed++;
      cycle();
      total++; if (out_valid !== 1'b1 || out_op !== 5'd1 || out_a !== 32'd5 || out_b !== 32'd7 || out_rd !== 5'd9)
        $display("FAIL bp_hold[%0d] got v=%b op=%0d a=%0d b=%0d rd=%0d want 1/1/5/7/9", i, out_valid, out_op, out_a, out_b, out_rd);
      else passed++;
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else passed++;
    cycle();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_op !== 5'd2 || out_a !== 32'd7 || out_b !== 32'd5 || out_rd !== 5'd10)
      $display("FAIL bp_next got v=%b op=%0d a=%0d b=%0d rd=%0d want 1/2/7/5/10", out_valid, out_op, out_a, out_b, out_rd);
    else passed++;
    cycle();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", out_valid); else passed++;
    wb_en = 1; wb_rd = 9; wb_data = 1; cycle();
    wb_rd = 10; wb_data = 2; cycle();
    wb_en = 0;
  endtask

  task automatic test_imm();
    in_valid = 1; in_instr = mk(5'd0, 5'd6, 5'd1, 5'd1, 1'b0, 11'd0);
    cycle();
    in_instr = mk(5'd0, 5'd7, 5'd0, 5'd6, 1'b1, 11'h7FF);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL imm_no_stall got %b want 1", in_ready); else passed++;
    cycle();
    in_valid = 0;
    total++; if (out_b !== 32'hFFFF_FFFF || out_a !== 32'd0) $display("FAIL imm_sext got a=%h b=%h want 0/ffffffff", out_a, out_b); else passed++;
    in_valid = 1; in_instr = mk(5'd0, 5'd11, 5'd0, 5'd6, 1'b0, 11'd0);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL imm_reg_stall got %b want 0", in_ready); else passed++;
    in_valid = 0;
    wb_en = 1; wb_rd = 6; wb_data = 3; cycle();
    wb_rd = 7; wb_data = 4; cycle();
    wb_en = 0;
  endtask

  task automatic test_illegal();
    in_valid = 1; in_instr = mk(5'd12, 5'd8, 5'd1, 5'd2, 1'b0, 11'd0);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL ill_ready got %b want 1", in_ready); else passed++;
    cycle();
    in_valid = 0;
    total++; if (illegal !== 1'b1 || out_valid !== 1'b0) $display("FAIL ill_pulse got ill=%b v=%b want 1/0", illegal, out_valid); else passed++;
    cycle();
    total++; if (illegal !== 1'b0) $display("FAIL ill_one_cycle got %b want 0", illegal); else passed++;
    in_instr = mk(5'd0, 5'd12, 5'd8, 5'd0, 1'b0, 11'd0);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL ill_no_pend got %b want 1", in_ready); else passed++;
    wb_en = 1; wb_rd = 0; wb_data = 32'hDEAD; cycle();
    wb_en = 0;
    in_valid = 1; in_instr = mk(5'd0, 5'd13, 5'd0, 5'd0, 1'b0, 11'd0);
    cycle();
    in_valid = 0;
    total++; if (out_a !== 32'd0 || out_b !== 32'd0) $display("FAIL r0_zero got a=%h b=%h want 0/0", out_a, out_b); else passed++;
    wb_en = 1; wb_rd = 13; wb_data = 0; cycle();
    wb_en = 0;
  endtask

  task automatic test_async_reset();
    idle(); cycle();
    out_ready = 0; in_valid = 1; in_instr = mk(5'd0, 5'd5, 5'd1, 5'd2, 1'b0, 11'd0);
    cycle();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL ares_pre_valid got %b want 1", out_valid); else passed++;
    #3 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_a !== 32'd0) $display("FAIL ares_drop got v=%b a=%h want 0/0", out_valid, out_a); else passed++;
    in_instr = mk(5'd0, 5'd6, 5'd5, 5'd0, 1'b0, 11'd0);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL ares_pend_clear got %b want 1", in_ready); else passed++;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = mk(5'($urandom_range(0, 13)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 11'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      total++; if (in_ready !== m_ready()) $display("FAIL rnd_ready[%0d] got %b want %b", n, in_ready, m_ready()); else passed++;
      cycle();
      total++; if (out_valid !== m_ov || illegal !== m_ill) $display("FAIL rnd_ctrl[%0d] got v=%b ill=%b want %b/%b", n, out_valid, illegal, m_ov, m_ill); else passed++;
      if (m_ov) begin
        total++; if (out_a !== m_a || out_b !== m_b || out_op !== m_op || out_rd !== m_rd)
          $display("FAIL rnd_data[%0d] got a=%h b=%h op=%0d rd=%0d want %h/%h/%0d/%0d", n, out_a, out_b, out_op, out_rd, m_a, m_b, m_op, m_rd);
        else passed++;
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_bypass();
    test_backpressure();
    test_imm();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
